// File: rtl/axi_mem_slave_if.sv
// rtl/axi_mem_slave_if.sv - AXI4 write/read channel bundle between an initiator and axi_mem_slave
interface axi_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI4 responder backed by a word-addressed RAM
// Independent write and read FSMs, one outstanding burst each, registered handshake outputs.
module axi_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_BYTES  = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  axi_mem_slave_if.slave s_axi
);
  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int BYTE_AW = $clog2(BYTES);
  localparam int MEM_AW  = $clog2(MEM_BYTES);
  localparam int WORDS   = MEM_BYTES / BYTES;
  localparam int WORD_AW = MEM_AW - BYTE_AW;

  localparam logic [2:0] BEAT_SIZE   = 3'(BYTE_AW);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // DECERR outranks SLVERR; burst[1] covers both WRAP and the reserved encoding.
  function automatic logic [1:0] beat_code(input logic [ADDR_WIDTH-1:0] addr,
                                           input logic [2:0]            size,
                                           input logic [1:0]            burst);
    if (|addr[ADDR_WIDTH-1:MEM_AW]) return RESP_DECERR;
    if (burst[1] || (size != BEAT_SIZE)) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [1:0]            burst);
    if (burst == BURST_FIXED) return addr;
    return {addr[ADDR_WIDTH-1:BYTE_AW], {BYTE_AW{1'b0}}} + ADDR_WIDTH'(BYTES);
  endfunction

  function automatic logic [WORD_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[MEM_AW-1:BYTE_AW];
  endfunction

  // Response codes are ordered so the numerically larger one is the worse one.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // ---------------------------------------------------------------- write path
  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_beat;
  logic [2:0]            w_size;
  logic [1:0]            w_burst, w_resp;
  logic                  awready_q, wready_q, bvalid_q;
  logic                  aw_hs, w_hs, b_hs, w_last_beat;
  logic [1:0]            w_code, w_beat_resp;

  assign aw_hs       = s_axi.awvalid & awready_q;
  assign w_hs        = s_axi.wvalid & wready_q;
  assign b_hs        = bvalid_q & s_axi.bready;
  assign w_last_beat = (w_beat == w_len);
  assign w_code      = beat_code(w_addr, w_size, w_burst);
  assign w_beat_resp = worst(w_code, (s_axi.wlast != w_last_beat) ? RESP_SLVERR : RESP_OKAY);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_beat    <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_resp    <= RESP_OKAY;
    end else begin
      w_state   <= w_next;
      awready_q <= (w_next == W_IDLE);
      wready_q  <= (w_next == W_DATA);
      bvalid_q  <= (w_next == W_RESP);
      if (aw_hs) begin
        w_id    <= s_axi.awid;
        w_addr  <= s_axi.awaddr;
        w_len   <= s_axi.awlen;
        w_size  <= s_axi.awsize;
        w_burst <= s_axi.awburst;
        w_beat  <= '0;
        w_resp  <= RESP_OKAY;
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_burst);
        w_beat <= w_beat + 8'd1;
        w_resp <= worst(w_resp, w_beat_resp);
      end
    end
  end

  // Error beats are dropped; only the address/size/burst check gates the RAM, not wlast.
  always_ff @(posedge clk) begin
    if (w_hs && (w_code == RESP_OKAY)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi.wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = w_id;
  assign s_axi.bresp   = w_resp;

  // ----------------------------------------------------------------- read path
  r_state_t              r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_beat;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  ar_hs, r_hs;
  logic [ADDR_WIDTH-1:0] r_load_addr;
  logic [2:0]            r_load_size;
  logic [1:0]            r_load_burst, r_load_code;

  assign ar_hs = s_axi.arvalid & arready_q;
  assign r_hs  = rvalid_q & s_axi.rready;

  always_comb begin
    r_next = r_state;
    if (r_state == R_IDLE) begin
      if (ar_hs) r_next = R_DATA;
    end else begin
      if (r_hs && rlast_q) r_next = R_IDLE;
    end
  end

  // Beat to be registered next: beat 0 straight off AR, otherwise the stepped address.
  always_comb begin
    r_load_addr  = s_axi.araddr;
    r_load_size  = s_axi.arsize;
    r_load_burst = s_axi.arburst;
    if (r_state == R_DATA) begin
      r_load_addr  = next_addr(r_addr, r_burst);
      r_load_size  = r_size;
      r_load_burst = r_burst;
    end
  end

  assign r_load_code = beat_code(r_load_addr, r_load_size, r_load_burst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_size    <= '0;
      r_burst   <= '0;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      rvalid_q  <= (r_next == R_DATA);
      if (ar_hs) begin
        r_id    <= s_axi.arid;
        r_addr  <= r_load_addr;
        r_len   <= s_axi.arlen;
        r_size  <= s_axi.arsize;
        r_burst <= s_axi.arburst;
        r_beat  <= '0;
        rdata_q <= (r_load_code == RESP_OKAY) ? mem[word_idx(r_load_addr)] : '0;
        rresp_q <= r_load_code;
        rlast_q <= (s_axi.arlen == 8'd0);
      end else if (r_hs && !rlast_q) begin
        r_addr  <= r_load_addr;
        r_beat  <= r_beat + 8'd1;
        rdata_q <= (r_load_code == RESP_OKAY) ? mem[word_idx(r_load_addr)] : '0;
        rresp_q <= r_load_code;
        rlast_q <= ((r_beat + 8'd1) == r_len);
      end
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rid     = r_id;
endmodule
